counter_4bit: RTL and testbench

//   4-bit synchronous up-counter built from four toggle (T) flip-flops in a ripple-enable chain.
//   T0 is the count enable. The state is exposed both as individual bits (Q0..Q3) and as a bus (Y).

---
 rtl/counter_4bit_pkg.sv | 7 +
 rtl/counter_4bit_t_ff.sv | 18 +
 rtl/counter_4bit.sv | 40 ++++
 tb/tb_counter_4bit.sv | 108 ++++++++++
 4 files changed

// File: rtl/counter_4bit_pkg.sv
// Shared constants for the 4-bit T flip-flop counter.
// Exports the counter width used by the top level.
package counter_4bit_pkg;

  localparam int CNT_W = 4;

endpackage

// File: rtl/counter_4bit_t_ff.sv
// Toggle flip-flop with synchronous active-high reset.
// Ports: clk, reset (sync, high), t (toggle enable), q (state).
module t_ff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/counter_4bit.sv
// 4-bit synchronous up-counter from four T flip-flops.
// Ports: clk, reset (sync, high), T0 (count enable), Q0..Q3 bits, Y bus.
module counter_4bit
  import counter_4bit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       T0,
  output logic       Q0,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic [3:0] Y
);

  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] t;

  // Stage n toggles only when every lower stage is 1 (carry ripple).
  assign t[0] = T0;
  assign t[1] = t[0] & q[0];
  assign t[2] = t[1] & q[1];
  assign t[3] = t[2] & q[2];

  for (genvar i = 0; i < CNT_W; i++) begin : g_stage
    t_ff u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];
  assign Y  = {Q3, Q2, Q1, Q0};

endmodule

// File: tb/tb_counter_4bit.sv
// Self-checking bench for counter_4bit.
// Scoreboard of expected counts, checked after each clock edge.
module tb_counter_4bit;

  logic       clk;
  logic       reset;
  logic       T0;
  logic       Q0, Q1, Q2, Q3;
  logic [3:0] Y;

  int vectors;
  int miscompares;

  logic [3:0] model;
  logic [3:0] sb_q[$];

  counter_4bit dut (
    .clk   (clk),
    .reset (reset),
    .T0    (T0),
    .Q0    (Q0),
    .Q1    (Q1),
    .Q2    (Q2),
    .Q3    (Q3),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic t0);
    logic [3:0] e;
    @(negedge clk);
    reset = rst;
    T0    = t0;
    if (rst) model = 4'h0;
    else if (t0) model = model + 4'h1;
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 expected 1");
    end else begin
      e = sb_q.pop_front();
      cmp("Y",  Y, e);
      cmp("Q0", {3'b0, Q0}, {3'b0, e[0]});
      cmp("Q1", {3'b0, Q1}, {3'b0, e[1]});
      cmp("Q2", {3'b0, Q2}, {3'b0, e[2]});
      cmp("Q3", {3'b0, Q3}, {3'b0, e[3]});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model       = 4'h0;
    reset       = 1'b0;
    T0          = 1'b0;

    step(1'b1, 1'b0);
    cmp("reset_y", Y, 4'h0);

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cmp("idle_hold", Y, 4'h0);

    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    cmp("count_15", Y, 4'hF);

    step(1'b0, 1'b1);
    cmp("wrap", Y, 4'h0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    cmp("count_18", Y, 4'h2);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    cmp("reach_6", Y, 4'h6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    cmp("hold_6", Y, 4'h6);
    step(1'b0, 1'b1);
    cmp("resume_7", Y, 4'h7);

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    cmp("reach_9", Y, 4'h9);
    step(1'b1, 1'b1);
    cmp("reset_prio", Y, 4'h0);
    step(1'b0, 1'b1);
    cmp("restart_1", Y, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
